// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath with a shared memory port.
// Optional retired-instruction counter enabled by defining INSTRET_EN.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [11:0]      imm,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             alu_latch,
    output logic             reg_we,
    output logic             pc_we,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [TW-1:0] tcnt;
    logic          is_load;
    logic          is_store;
    logic          is_branch;
    logic          legal_op;
    logic          waiting;
    logic          timeout_hit;

    assign is_load   = (op == OP_LOAD);
    assign is_store  = (op == OP_STORE);
    assign is_branch = (op == OP_BRANCH);

    always_comb begin
        legal_op = 1'b0;
        case (op)
            OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    end

    assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    // A late mem_ready on the limit cycle still completes the access.
    assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (tcnt == TW'(MEM_TIMEOUT));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_DECODE: begin
                if (op == OP_SYSTEM) begin
                    if (funct3 == 3'b000 && (imm == 12'h000 || imm == 12'h001))
                        state_d = S_HALT;
                    else
                        state_d = S_FAULT;
                end else if (legal_op) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                if (is_load || is_store) state_d = S_MEM;
                else if (is_branch)      state_d = S_FETCH;
                else                     state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready)        state_d = is_load ? S_WB : S_FETCH;
                else if (timeout_hit) state_d = S_FAULT;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tcnt    <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                tcnt <= '0;
            else if (waiting && MEM_TIMEOUT != 0)
                tcnt <= tcnt + 1'b1;
        end
    end

    assign state        = state_q;
    assign mem_req      = (state_q == S_FETCH) || (state_q == S_MEM);
    assign mem_addr_sel = (state_q == S_MEM);
    assign mem_we       = (state_q == S_MEM) && is_store;
    assign ir_we        = (state_q == S_FETCH) && mem_ready;
    assign alu_latch    = (state_q == S_EXEC);
    assign reg_we       = (state_q == S_WB);
    assign pc_we        = (state_q == S_WB)
                        || ((state_q == S_EXEC) && is_branch)
                        || ((state_q == S_MEM) && is_store && mem_ready);
    assign halted       = (state_q == S_HALT);
    assign fault        = (state_q == S_FAULT);

`ifdef INSTRET_EN
    logic [CNT_W-1:0] ret_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            ret_cnt <= '0;
        else if (pc_we)
            ret_cnt <= ret_cnt + 1'b1;
    end

    assign instret = ret_cnt;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected output vectors are queued per cycle and
// compared against the sampled DUT outputs; MEM_TIMEOUT=3 and CNT_W=4 for boundary cases.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [11:0] imm;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, alu_latch, reg_we, pc_we;
    logic       halted, fault;
    logic [2:0] state;
    logic [3:0] instret;

    logic [12:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .funct3(funct3), .imm(imm),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .alu_latch(alu_latch),
        .reg_we(reg_we), .pc_we(pc_we), .halted(halted), .fault(fault),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // Expected output vector from the state and the opcode currently presented.
    function automatic logic [12:0] vec(input logic [2:0] st, input logic [6:0] o, input logic rdy);
        logic f, m, e, w;
        f = (st == 3'd1);
        e = (st == 3'd3);
        m = (st == 3'd4);
        w = (st == 3'd5);
        return {st, f | m, m & (o == 7'b0100011), m, f & rdy, e, w,
                w | (e & (o == 7'b1100011)) | (m & (o == 7'b0100011) & rdy),
                st == 3'd6, st == 3'd7};
    endfunction

    function automatic logic [12:0] obs();
        return {state, mem_req, mem_we, mem_addr_sel, ir_we, alu_latch, reg_we, pc_we,
                halted, fault};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        op = 7'b0010011; funct3 = 3'd0; imm = 12'd0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(vec(3'd0, op, 1'b0));
            @(negedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL reset_idle cyc%0d got %h exp %h", i, obs(), e); end
        end
        n_tests++;
        if (instret !== 4'd0) begin n_fail++; $display("FAIL reset_instret got %0d exp 0", instret); end
        start = 1'b1;
        exp_q.push_back(vec(3'd1, op, 1'b0));
        @(negedge clk); start = 1'b0; mem_ready = 1'b0; #1;
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_fetch_wait got %h exp %h", obs(), e); end
        rst_n = 1'b0;
        exp_q.push_back(vec(3'd0, op, 1'b0));
        @(negedge clk); #1;
        e = exp_q.pop_front();
        n_tests++;
        if (obs() !== e) begin n_fail++; $display("FAIL reset_mid_access got %h exp %h", obs(), e); end
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        logic [2:0] sts[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
        logic [12:0] e;
        do_reset();
        op = 7'b0010011;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vec(sts[i], op, 1'b1));
            @(negedge clk); start = (i == 0); mem_ready = 1'b1; #1;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL addi cyc%0d got %h exp %h", i, obs(), e); end
        end
    endtask

    task automatic test_load_wait();
        logic [2:0] sts[10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
        logic       rdy[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [12:0] e;
        do_reset();
        op = 7'b0000011;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(vec(sts[i], op, rdy[i]));
            @(negedge clk); start = (i == 0); mem_ready = rdy[i]; #1;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL load_wait cyc%0d got %h exp %h", i, obs(), e); end
        end
    endtask

    task automatic test_store_branch();
        logic [2:0] sts_s[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        logic [2:0] sts_b[4] = '{3'd2, 3'd3, 3'd1, 3'd2};
        logic [12:0] e;
        do_reset();
        op = 7'b0100011;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vec(sts_s[i], op, 1'b1));
            @(negedge clk); start = (i == 0); mem_ready = 1'b1; #1;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL store cyc%0d got %h exp %h", i, obs(), e); end
        end
        op = 7'b1100011;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(vec(sts_b[i], op, 1'b1));
            @(negedge clk); mem_ready = 1'b1; #1;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL branch cyc%0d got %h exp %h", i, obs(), e); end
        end
        n_tests++;
`ifdef INSTRET_EN
        if (instret !== 4'd2) begin n_fail++; $display("FAIL instret_store_branch got %0d exp 2", instret); end
`else
        if (instret !== 4'd0) begin n_fail++; $display("FAIL instret_store_branch got %0d exp 0", instret); end
`endif
    endtask

    // Walks one system/illegal instruction to DECODE and checks the sticky end state.
    task automatic test_halt_fault();
        logic [6:0]  ops[4] = '{7'b1110011, 7'b1110011, 7'b1110011, 7'b0000000};
        logic [11:0] imms[4] = '{12'h001, 12'h000, 12'h002, 12'h000};
        logic [2:0]  fin[4] = '{3'd6, 3'd6, 3'd7, 3'd7};
        logic [2:0]  sts[7];
        logic [12:0] e;
        for (int t = 0; t < 4; t++) begin
            do_reset();
            op = ops[t]; imm = imms[t]; funct3 = 3'd0;
            sts = '{3'd0, 3'd1, 3'd2, fin[t], fin[t], fin[t], fin[t]};
            for (int i = 0; i < 7; i++) begin
                exp_q.push_back(vec(sts[i], op, 1'b1));
                @(negedge clk);
                start = (i == 0) || (i >= 4 && $urandom_range(0, 1) == 1);
                mem_ready = 1'b1; #1;
                e = exp_q.pop_front();
                n_tests++;
                if (obs() !== e) begin n_fail++; $display("FAIL sys%0d cyc%0d got %h exp %h", t, i, obs(), e); end
            end
            rst_n = 1'b0;
            exp_q.push_back(vec(3'd0, op, 1'b1));
            @(negedge clk); #1;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL sys%0d_reset got %h exp %h", t, obs(), e); end
            rst_n = 1'b1;
        end
        imm = 12'd0;
    endtask

    task automatic test_timeout();
        logic [2:0] sts[7] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd7, 3'd7};
        logic [12:0] e;
        do_reset();
        op = 7'b0010011;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vec(sts[i], op, 1'b0));
            @(negedge clk); start = (i == 0) || (i == 6); mem_ready = 1'b0; #1;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL timeout cyc%0d got %h exp %h", i, obs(), e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ph[4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        logic [12:0] e;
        logic [2:0]  st;
        logic [3:0]  exp_ret;
        do_reset();
        op = 7'b0010011;
        for (int k = 0; k < 70; k++) begin
            st = (k == 0) ? 3'd0 : ph[(k - 1) % 4];
            exp_q.push_back(vec(st, op, 1'b1));
            @(negedge clk); start = 1'b1; mem_ready = 1'b1; #1;
            e = exp_q.pop_front();
            n_tests++;
            if (obs() !== e) begin n_fail++; $display("FAIL b2b cyc%0d got %h exp %h", k, obs(), e); end
        end
`ifdef INSTRET_EN
        exp_ret = 4'd1;
`else
        exp_ret = 4'd0;
`endif
        n_tests++;
        if (instret !== exp_ret) begin n_fail++; $display("FAIL instret_wrap got %0d exp %0d", instret, exp_ret); end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
        op = 7'd0; funct3 = 3'd0; imm = 12'd0;
        test_reset();
        test_addi();
        test_load_wait();
        test_store_branch();
        test_halt_fault();
        test_timeout();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
